// File: rtl/seg7_if.sv
// Load-side bus of the 7-segment scan driver: one-cycle strobe plus the
// value/digit-enable/decimal-point data it captures.
interface seg7_if #(
  parameter int NUM_DIGITS = 8
);
  logic                  load;
  logic [31:0]           value;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [NUM_DIGITS-1:0] dp_en;

  modport master (output load, value, digit_en, dp_en);
  modport slave  (input  load, value, digit_en, dp_en);
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with per-slot anti-ghost blanking.
// Loads are held pending and applied only at frame boundaries (tear-free).
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_if.slave                 bus,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_done
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [31:0]           r_val_disp, r_val_pend;
  logic [NUM_DIGITS-1:0] r_en_disp, r_en_pend;
  logic [NUM_DIGITS-1:0] r_dp_disp, r_dp_pend;
  logic                  r_pend_vld;

  logic                  w_cnt_last, w_idx_last, w_frame, w_blank;
  logic [3:0]            w_nib;
  logic [7:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_an;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_cnt_last = (r_cnt == CW'(CLK_DIV - 1));
  assign w_idx_last = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_frame    = w_cnt_last && w_idx_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
      if (w_cnt_last)
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
    end
  end

  // A load landing on the boundary bypasses the pending stage entirely,
  // so nothing is left behind to re-apply at the next frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_val_disp <= '0;
      r_en_disp  <= '0;
      r_dp_disp  <= '0;
      r_val_pend <= '0;
      r_en_pend  <= '0;
      r_dp_pend  <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_frame) begin
      if (bus.load) begin
        r_val_disp <= bus.value;
        r_en_disp  <= bus.digit_en;
        r_dp_disp  <= bus.dp_en;
      end else if (r_pend_vld) begin
        r_val_disp <= r_val_pend;
        r_en_disp  <= r_en_pend;
        r_dp_disp  <= r_dp_pend;
      end
      r_pend_vld <= 1'b0;
    end else if (bus.load) begin
      r_val_pend <= bus.value;
      r_en_pend  <= bus.digit_en;
      r_dp_pend  <= bus.dp_en;
      r_pend_vld <= 1'b1;
    end
  end

  assign w_blank = (r_cnt < CW'(BLANK_CYCLES)) || !r_en_disp[r_idx];
  assign w_nib   = r_val_disp[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_an  = '1;
    w_seg = 8'hFF;
    if (!w_blank) begin
      w_an  = ~(NUM_DIGITS'(1) << r_idx);
      w_seg = {~r_dp_disp[r_idx], hex7(w_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_out    <= 8'hFF;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= w_seg;
      an_out     <= w_an;
      frame_done <= w_frame;
    end
  end
endmodule
